// File: rtl/mmio_bridge.sv
// mmio_bridge: splits the cpu byte bus into 128KB RAM and an I/O page holding the
// UART FIFOs, a free-running cycle counter and the program-stop latch.
module mmio_bridge #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    input  logic [7:0]  ram_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam logic [17:0] A_UART = 18'h30000;
    localparam logic [17:0] A_CNT0 = 18'h30004;
    localparam logic [17:0] A_CNT1 = 18'h30005;
    localparam logic [17:0] A_CNT2 = 18'h30006;
    localparam logic [17:0] A_CNT3 = 18'h30007;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_RAM  = 3'd1,
        SEL_RX   = 3'd2,
        SEL_CNT0 = 3'd3,
        SEL_CNT1 = 3'd4,
        SEL_CNT2 = 3'd5,
        SEL_CNT3 = 3'd6,
        SEL_ZERO = 3'd7
    } rd_sel_e;

    rd_sel_e      sel_q, sel_d;
    logic [7:0]   data_q, data_d, hold_q;
    logic [31:0]  cnt_q, snap_q, snap_d;
    logic         stop_q, ovf_q;
    logic [7:0]   tx_mem [TX_DEPTH];
    logic [7:0]   rx_mem [RX_DEPTH];
    logic [TXW:0] tx_wp_q, tx_rp_q;
    logic [RXW:0] rx_wp_q, rx_rp_q;

    logic [17:0]  addr_s;
    logic         is_io_s, wr_s, rd_s;
    logic         tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
    logic         tx_req_s, tx_pop_s, tx_push_s, rx_pop_s, rx_push_s;
    logic [7:0]   tx_byte_s;
    logic         unused_s;

    assign addr_s     = cpu_a[17:0];
    assign unused_s   = ^cpu_a[31:18];
    assign is_io_s    = (addr_s[17:16] == 2'b11);
    assign wr_s       = rdy_in & cpu_wr;
    assign rd_s       = rdy_in & ~cpu_wr;

    assign tx_empty_s = (tx_wp_q == tx_rp_q);
    assign tx_full_s  = (tx_wp_q[TXW] != tx_rp_q[TXW]) && (tx_wp_q[TXW-1:0] == tx_rp_q[TXW-1:0]);
    assign rx_empty_s = (rx_wp_q == rx_rp_q);
    assign rx_full_s  = (rx_wp_q[RXW] != rx_rp_q[RXW]) && (rx_wp_q[RXW-1:0] == rx_rp_q[RXW-1:0]);

    // A stop write always enqueues a 0x00 marker; zero bytes to the UART port are dropped.
    assign tx_req_s   = ~stop_q & wr_s &
                        (((addr_s == A_UART) & (cpu_dout != 8'h00)) | (addr_s == A_CNT0));
    assign tx_byte_s  = (addr_s == A_CNT0) ? 8'h00 : cpu_dout;
    assign tx_pop_s   = ~tx_empty_s & tx_ready;
    assign tx_push_s  = tx_req_s & (~tx_full_s | tx_pop_s);
    assign rx_pop_s   = rd_s & (addr_s == A_UART) & ~rx_empty_s;
    assign rx_push_s  = rx_valid & ~rx_full_s;

    assign ram_a        = cpu_a[16:0];
    assign ram_dout     = cpu_dout;
    assign ram_wr       = rst_in & wr_s & ~is_io_s;
    assign tx_data      = tx_mem[tx_rp_q[TXW-1:0]];
    assign tx_valid     = ~tx_empty_s;
    assign rx_ready     = ~rx_full_s;
    assign program_stop = stop_q;
    assign tx_overflow  = ovf_q;

    // Read decode: choose next cycle's cpu_din source and load the I/O data register.
    always_comb begin
        sel_d  = sel_q;
        data_d = data_q;
        snap_d = snap_q;
        if (rd_s) begin
            if (!is_io_s) begin
                sel_d = SEL_RAM;
            end else begin
                case (addr_s)
                    A_UART: begin
                        sel_d  = SEL_RX;
                        data_d = rx_empty_s ? 8'h00 : rx_mem[rx_rp_q[RXW-1:0]];
                    end
                    A_CNT0: begin
                        sel_d  = SEL_CNT0;
                        data_d = cnt_q[7:0];
                        snap_d = cnt_q;
                    end
                    A_CNT1: begin
                        sel_d  = SEL_CNT1;
                        data_d = snap_q[15:8];
                    end
                    A_CNT2: begin
                        sel_d  = SEL_CNT2;
                        data_d = snap_q[23:16];
                    end
                    A_CNT3: begin
                        sel_d  = SEL_CNT3;
                        data_d = snap_q[31:24];
                    end
                    default: begin
                        sel_d  = SEL_ZERO;
                        data_d = 8'h00;
                    end
                endcase
            end
        end else if (wr_s) begin
            sel_d = SEL_NONE;
        end else begin
            sel_d = sel_q;
        end
    end

    // Read return mux: SEL_NONE replays whatever cpu_din showed last cycle.
    always_comb begin
        case (sel_q)
            SEL_NONE: cpu_din = hold_q;
            SEL_RAM:  cpu_din = ram_din;
            SEL_ZERO: cpu_din = 8'h00;
            default:  cpu_din = data_q;
        endcase
    end

    // Control state, counter and FIFO pointers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sel_q   <= SEL_NONE;
            data_q  <= 8'h00;
            hold_q  <= 8'h00;
            snap_q  <= 32'h0000_0000;
            cnt_q   <= 32'h0000_0000;
            stop_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            sel_q  <= sel_d;
            data_q <= data_d;
            hold_q <= cpu_din;
            snap_q <= snap_d;
            cnt_q  <= cnt_q + 32'd1;
            if (wr_s && (addr_s == A_CNT0)) stop_q <= 1'b1;
            if (tx_req_s && !tx_push_s)     ovf_q  <= 1'b1;
            if (tx_push_s) tx_wp_q <= tx_wp_q + (TXW+1)'(1);
            if (tx_pop_s)  tx_rp_q <= tx_rp_q + (TXW+1)'(1);
            if (rx_push_s) rx_wp_q <= rx_wp_q + (RXW+1)'(1);
            if (rx_pop_s)  rx_rp_q <= rx_rp_q + (RXW+1)'(1);
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_in) begin
        if (tx_push_s) tx_mem[tx_wp_q[TXW-1:0]] <= tx_byte_s;
        if (rx_push_s) rx_mem[rx_wp_q[RXW-1:0]] <= rx_data;
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: queue-based reference model compared every cycle,
// plus hand-computed expectations at the interesting points.
module tb_mmio_bridge;
    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, cpu_wr, tx_ready, rx_valid;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout, rx_data, ram_din;
    logic [7:0]  cpu_din, ram_dout, tx_data;
    logic [16:0] ram_a;
    logic        ram_wr, tx_valid, rx_ready, program_stop, tx_overflow;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    bit   [7:0]  ram_dev [0:131071];
    bit   [7:0]  m_ram   [0:131071];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [31:0] m_cnt  = 32'd0;
    logic [31:0] m_snap = 32'd0;
    logic [7:0]  m_din  = 8'd0;
    logic        m_stop = 1'b0;
    logic        m_ovf  = 1'b0;

    mmio_bridge #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .cpu_a(cpu_a),
        .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din), .ram_a(ram_a),
        .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .program_stop(program_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM device behind the bridge.
    always @(posedge clk_in) begin
        ram_din <= ram_dev[ram_a];
        if (ram_wr) ram_dev[ram_a] <= ram_dout;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the bus should look like after each clock edge.
    initial begin : model
        logic [17:0] a;
        logic        rx_full_b;
        logic [31:0] sh;
        forever begin
            @(posedge clk_in or negedge rst_in);
            if (!rst_in) begin
                tx_q.delete();
                rx_q.delete();
                m_cnt = 32'd0; m_snap = 32'd0; m_din = 8'd0; m_stop = 1'b0; m_ovf = 1'b0;
            end else begin
                a = cpu_a[17:0];
                rx_full_b = (rx_q.size() == RX_DEPTH);
                if (tx_ready && tx_q.size() != 0) void'(tx_q.pop_front());
                if (rdy_in && cpu_wr) begin
                    if (!m_stop && ((a == 18'h30000 && cpu_dout != 8'h00) || a == 18'h30004)) begin
                        if (tx_q.size() < TX_DEPTH) tx_q.push_back((a == 18'h30004) ? 8'h00 : cpu_dout);
                        else m_ovf = 1'b1;
                    end
                    if (a == 18'h30004) m_stop = 1'b1;
                    if (a[17:16] != 2'b11) m_ram[a[16:0]] = cpu_dout;
                end else if (rdy_in) begin
                    if (a[17:16] != 2'b11) m_din = m_ram[a[16:0]];
                    else if (a == 18'h30000) m_din = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                    else if (a == 18'h30004) begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
                    else if (a >= 18'h30005 && a <= 18'h30007) begin
                        sh = m_snap >> (8 * (a - 18'h30004));
                        m_din = sh[7:0];
                    end else m_din = 8'h00;
                end
                if (rx_valid && !rx_full_b) rx_q.push_back(rx_data);
                m_cnt = m_cnt + 32'd1;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clk_in);
        if (chk_on) begin
            chk("cpu_din", cpu_din, m_din);
            chk("tx_valid", tx_valid, tx_q.size() != 0);
            if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
            chk("rx_ready", rx_ready, rx_q.size() < RX_DEPTH);
            chk("program_stop", program_stop, m_stop);
            chk("tx_overflow", tx_overflow, m_ovf);
            chk("ram_wr", ram_wr, rst_in && rdy_in && cpu_wr && (cpu_a[17:16] != 2'b11));
        end
    end

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic acc(input logic wr, input logic [17:0] a, input logic [7:0] d);
        rdy_in = 1'b1; cpu_wr = wr; cpu_a = {14'd0, a}; cpu_dout = d;
        step();
        rdy_in = 1'b0; cpu_wr = 1'b0;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; cpu_wr = 1'b1; cpu_a = 32'd0; cpu_dout = 8'd0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        chk_on = 1'b1;
        step(); step();
        chk("rst_cpu_din", cpu_din, 8'h00);
        chk("rst_ram_wr", ram_wr, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_tx_valid", tx_valid, 1'b0);
        rdy_in = 1'b0; cpu_wr = 1'b0;
        rst_in = 1'b1;
        step();

        acc(1'b1, 18'h00010, 8'hA5);
        acc(1'b0, 18'h00010, 8'h00);
        chk("ram_rd_lit", cpu_din, 8'hA5);

        acc(1'b1, 18'h30000, 8'h41);
        acc(1'b1, 18'h30000, 8'h00);
        acc(1'b1, 18'h30000, 8'h42);
        chk("tx_two_valid", tx_valid, 1'b1);
        chk("tx_model_depth", tx_q.size(), 2);
        chk("tx_head_41", tx_data, 8'h41);
        tx_ready = 1'b1;
        step();
        chk("tx_head_42", tx_data, 8'h42);
        step();
        chk("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        rx_valid = 1'b1; rx_data = 8'h11; step();
        rx_data = 8'h22; step();
        rx_valid = 1'b0;
        acc(1'b0, 18'h30000, 8'h00); chk("rx_pop_11", cpu_din, 8'h11);
        acc(1'b0, 18'h30000, 8'h00); chk("rx_pop_22", cpu_din, 8'h22);
        rx_valid = 1'b1; rx_data = 8'h33;
        acc(1'b0, 18'h30000, 8'h00); chk("rx_empty_race", cpu_din, 8'h00);
        rx_valid = 1'b0;
        acc(1'b0, 18'h30000, 8'h00); chk("rx_pop_33", cpu_din, 8'h33);
        rx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rx_data = 8'h80 + 8'(i);
            step();
        end
        rx_valid = 1'b0;
        chk("rx_full", rx_ready, 1'b0);
        for (int i = 0; i < 16; i++) begin
            acc(1'b0, 18'h30000, 8'h00);
            chk("rx_drain", cpu_din, 8'h80 + 8'(i));
        end

        for (int i = 0; i < 17; i++) acc(1'b1, 18'h30000, 8'h01 + 8'(i));
        chk("tx_ovf_flag", tx_overflow, 1'b1);
        chk("tx_ovf_depth", tx_q.size(), 16);
        chk("tx_ovf_head", tx_data, 8'h01);
        acc(1'b0, 18'h30000, 8'h00);
        chk("rx_empty_read", cpu_din, 8'h00);

        tx_ready = 1'b1;
        repeat (16) step();
        chk("tx_empty_again", tx_valid, 1'b0);
        tx_ready = 1'b0;
        acc(1'b1, 18'h30004, 8'h77);
        chk("stop_set", program_stop, 1'b1);
        chk("stop_marker_valid", tx_valid, 1'b1);
        chk("stop_marker_data", tx_data, 8'h00);
        tx_ready = 1'b1;
        step();
        acc(1'b1, 18'h30000, 8'h55);
        step();
        chk("stop_blocks_tx", tx_valid, 1'b0);
        tx_ready = 1'b0;
        acc(1'b1, 18'h00020, 8'h3C);
        acc(1'b0, 18'h00020, 8'h00);
        chk("ram_after_stop", cpu_din, 8'h3C);

        acc(1'b0, 18'h00010, 8'h00);
        chk("pause_first", cpu_din, 8'hA5);
        cpu_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pause_din", cpu_din, 8'hA5);
            chk("pause_ram_wr", ram_wr, 1'b0);
        end
        #1 rst_in = 1'b0;
        #1;
        chk("arst_cpu_din", cpu_din, 8'h00);
        chk("arst_tx_valid", tx_valid, 1'b0);
        chk("arst_rx_ready", rx_ready, 1'b1);
        chk("arst_stop", program_stop, 1'b0);
        chk("arst_ovf", tx_overflow, 1'b0);
        chk("arst_ram_wr", ram_wr, 1'b0);
        cpu_wr = 1'b0;

        step();
        rst_in = 1'b1;
        repeat (255) step();
        acc(1'b0, 18'h30004, 8'h00); chk("cnt_b0", cpu_din, 8'hFF);
        acc(1'b0, 18'h30005, 8'h00); chk("cnt_b1", cpu_din, 8'h00);
        acc(1'b0, 18'h30006, 8'h00); chk("cnt_b2", cpu_din, 8'h00);
        acc(1'b0, 18'h30007, 8'h00); chk("cnt_b3", cpu_din, 8'h00);
        acc(1'b0, 18'h30004, 8'h00); chk("cnt_relatch_b0", cpu_din, 8'h03);
        acc(1'b0, 18'h30005, 8'h00); chk("cnt_relatch_b1", cpu_din, 8'h01);

        acc(1'b1, 18'h30008, 8'h12);
        acc(1'b0, 18'h30008, 8'h00); chk("io_other_rd", cpu_din, 8'h00);
        chk("io_other_wr", tx_valid, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
